// File: rtl/mips16_dbg_pkg.sv
// Debug/run-control definitions shared by the MIPS16 run sequencer.
// Holds the host command encodings, the sequencer state encoding and the
// default length of the core reset pulse.
package mips16_dbg_pkg;

  // Host command opcodes (cmd_op)
  localparam logic [2:0] OpNop      = 3'd0;
  localparam logic [2:0] OpRun      = 3'd1;
  localparam logic [2:0] OpHalt     = 3'd2;
  localparam logic [2:0] OpStep     = 3'd3;
  localparam logic [2:0] OpSetBp    = 3'd4;
  localparam logic [2:0] OpClrBp    = 3'd5;
  localparam logic [2:0] OpResetCpu = 3'd6;
  localparam logic [2:0] OpClrCnt   = 3'd7;

  typedef enum logic [1:0] {
    StHalt = 2'd0,
    StRun  = 2'd1,
    StStep = 2'd2,
    StCrst = 2'd3
  } run_state_e;

  localparam int unsigned CPU_RST_CYCLES = 2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk/rst (sync, active-high), en (count), clr (wins over en),
// cnt (current value, sticks at all-ones).
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [Width-1:0] cnt
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_q <= cnt_q + Width'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mips16_run_ctrl.sv
// Run/halt/step sequencer for the 16-bit single-cycle MIPS core.
// Ports: clk/rst (sync, active-high); host command port cmd_valid/cmd_ready/
// cmd_op/cmd_arg; pc from the core; cpu_en (core clock-enable) and cpu_rst
// (core sync reset) to the core; state, sticky bp_hit and saturating
// cycle_cnt for debug visibility.
module mips16_run_ctrl import mips16_dbg_pkg::*; #(
  parameter int unsigned PC_W       = 16,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned RST_CYCLES = CPU_RST_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [PC_W-1:0]  cmd_arg,
  input  logic [PC_W-1:0]  pc,
  output logic             cpu_en,
  output logic             cpu_rst,
  output logic [1:0]       state,
  output logic             bp_hit,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int unsigned RcW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  // CRST counts down from RST_CYCLES-1 to 0, giving RST_CYCLES cycles
  localparam logic [RcW-1:0] RcLoad = RcW'(RST_CYCLES - 1);

  run_state_e       state_q, state_d;
  logic             bp_en_q, bp_en_d;
  logic [PC_W-1:0]  bp_addr_q, bp_addr_d;
  logic             bp_hit_q, bp_hit_d;
  logic             resume_q, resume_d;
  logic [PC_W-1:0]  step_rem_q, step_rem_d;
  logic [RcW-1:0]   rst_cnt_q, rst_cnt_d;
  logic             accept;
  logic             bp_match;
  logic             cnt_clr;

  always_comb begin
    accept     = cmd_valid && (state_q != StCrst);
    // resume masks the match for the first RUN cycle so a halted core can
    // step off the breakpoint address
    bp_match   = bp_en_q && (pc == bp_addr_q) && !resume_q;
    state_d    = state_q;
    bp_en_d    = bp_en_q;
    bp_addr_d  = bp_addr_q;
    bp_hit_d   = bp_hit_q;
    resume_d   = resume_q;
    step_rem_d = step_rem_q;
    rst_cnt_d  = rst_cnt_q;
    cpu_en     = 1'b0;
    cpu_rst    = 1'b0;

    unique case (state_q)
      StHalt: begin
        if (accept && (cmd_op == OpRun)) begin
          state_d  = StRun;
          resume_d = 1'b1;
          bp_hit_d = 1'b0;
        end else if (accept && (cmd_op == OpStep)) begin
          state_d    = StStep;
          step_rem_d = (cmd_arg == '0) ? PC_W'(1) : cmd_arg;
          bp_hit_d   = 1'b0;
        end
      end
      StRun: begin
        cpu_en   = !bp_match;
        resume_d = 1'b0;
        if (bp_match) begin
          state_d  = StHalt;
          bp_hit_d = 1'b1;
        end else if (accept && (cmd_op == OpHalt)) begin
          state_d = StHalt;
        end
      end
      StStep: begin
        cpu_en     = 1'b1;
        step_rem_d = step_rem_q - PC_W'(1);
        if ((step_rem_q == PC_W'(1)) || (accept && (cmd_op == OpHalt))) begin
          state_d = StHalt;
        end
      end
      StCrst: begin
        cpu_rst = 1'b1;
        if (rst_cnt_q == '0) begin
          state_d = StHalt;
        end else begin
          rst_cnt_d = rst_cnt_q - RcW'(1);
        end
      end
      default: state_d = StHalt;
    endcase

    // Housekeeping commands apply in any non-CRST state; evaluated after the
    // state logic so CLR_BP and RESET_CPU win over a same-cycle bp_hit set.
    if (accept) begin
      case (cmd_op)
        OpSetBp: begin
          bp_addr_d = cmd_arg;
          bp_en_d   = 1'b1;
        end
        OpClrBp: begin
          bp_en_d  = 1'b0;
          bp_hit_d = 1'b0;
        end
        OpResetCpu: begin
          state_d   = StCrst;
          rst_cnt_d = RcLoad;
          bp_hit_d  = 1'b0;
          resume_d  = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StHalt;
      bp_en_q    <= 1'b0;
      bp_addr_q  <= '0;
      bp_hit_q   <= 1'b0;
      resume_q   <= 1'b0;
      step_rem_q <= '0;
      rst_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      bp_en_q    <= bp_en_d;
      bp_addr_q  <= bp_addr_d;
      bp_hit_q   <= bp_hit_d;
      resume_q   <= resume_d;
      step_rem_q <= step_rem_d;
      rst_cnt_q  <= rst_cnt_d;
    end
  end

  assign cnt_clr = accept && ((cmd_op == OpClrCnt) || (cmd_op == OpResetCpu));

  sat_counter #(
    .Width (CNT_W)
  ) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .en  (cpu_en),
    .clr (cnt_clr),
    .cnt (cycle_cnt)
  );

  assign cmd_ready = (state_q != StCrst);
  assign state     = state_q;
  assign bp_hit    = bp_hit_q;

endmodule

// File: tb/tb_mips16_run_ctrl.sv
// Bench for mips16_run_ctrl: directed bring-up sequence followed by random
// commands, all checked against an event-level reference model plus a tiny
// core model whose PC advances by 2 per enabled cycle and wraps at 16.
module tb_mips16_run_ctrl;
  import mips16_dbg_pkg::*;

  localparam int unsigned PcW       = 16;
  localparam int unsigned CntW      = 8;
  localparam int unsigned RstCycles = 2;
  localparam int          CntMax    = (1 << CntW) - 1;
  localparam int          PcWrap    = 16;

  logic            clk;
  logic            rst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [2:0]      cmd_op;
  logic [PcW-1:0]  cmd_arg;
  logic [PcW-1:0]  pc;
  logic            cpu_en;
  logic            cpu_rst;
  logic [1:0]      state;
  logic            bp_hit;
  logic [CntW-1:0] cycle_cnt;

  mips16_run_ctrl #(
    .PC_W       (PcW),
    .CNT_W      (CntW),
    .RST_CYCLES (RstCycles)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .pc        (pc),
    .cpu_en    (cpu_en),
    .cpu_rst   (cpu_rst),
    .state     (state),
    .bp_hit    (bp_hit),
    .cycle_cnt (cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input longint unsigned got,
                       input longint unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: mode 0 halted, 1 running, 2 stepping, 3 core in reset
  int m_mode, m_left, m_rst_left, m_bp_addr, m_cnt, core_pc;
  bit m_bp_en, m_hit, m_fresh;

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_rst_left = 0; m_bp_addr = 0; m_cnt = 0;
    m_bp_en = 0; m_hit = 0; m_fresh = 0; core_pc = 0;
  endtask

  task automatic cyc(input bit r, input bit v, input logic [2:0] op, input int arg);
    bit exp_en, got_en, got_rst, acc, at_bp;
    @(negedge clk);
    rst = r; cmd_valid = v; cmd_op = op; cmd_arg = PcW'(arg); pc = PcW'(core_pc);
    #1;
    at_bp  = m_bp_en && (core_pc == m_bp_addr) && !m_fresh;
    exp_en = (m_mode == 1 && !at_bp) || (m_mode == 2);
    check("cmd_ready", cmd_ready, m_mode != 3);
    check("cpu_en", cpu_en, exp_en);
    check("cpu_rst", cpu_rst, m_mode == 3);
    check("state", state, m_mode);
    check("bp_hit", bp_hit, m_hit);
    check("cycle_cnt", cycle_cnt, m_cnt);
    got_en = cpu_en; got_rst = cpu_rst;
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
    end else begin
      acc = v && (m_mode != 3);
      if (acc && (op == OpClrCnt || op == OpResetCpu)) m_cnt = 0;
      else if (exp_en && m_cnt < CntMax) m_cnt++;
      case (m_mode)
        0: if (acc && op == OpRun) begin
             m_mode = 1; m_fresh = 1; m_hit = 0;
           end else if (acc && op == OpStep) begin
             m_mode = 2; m_left = (arg == 0) ? 1 : arg; m_hit = 0;
           end
        1: begin
             m_fresh = 0;
             if (at_bp) begin m_mode = 0; m_hit = 1; end
             else if (acc && op == OpHalt) m_mode = 0;
           end
        2: begin
             m_left--;
             if (m_left == 0 || (acc && op == OpHalt)) m_mode = 0;
           end
        default: begin
             m_rst_left--;
             if (m_rst_left == 0) m_mode = 0;
           end
      endcase
      if (acc && op == OpSetBp) begin m_bp_addr = arg; m_bp_en = 1; end
      if (acc && op == OpClrBp) begin m_bp_en = 0; m_hit = 0; end
      if (acc && op == OpResetCpu) begin
        m_mode = 3; m_rst_left = RstCycles; m_hit = 0; m_fresh = 0;
      end
      // core model reacts to what the DUT actually drove
      if (got_rst) core_pc = 0;
      else if (got_en) core_pc = (core_pc + 2) % PcWrap;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, OpNop, 0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = OpNop; cmd_arg = '0; pc = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // STEP 3 from reset
    cyc(0, 1, OpStep, 3);
    idle(5);
    // Core reset to bring PC back to 0, then breakpoint at 6
    cyc(0, 1, OpResetCpu, 0);
    idle(3);
    cyc(0, 1, OpSetBp, 6);
    cyc(0, 1, OpRun, 0);
    idle(6);
    // Resume off the breakpoint; wraps around and halts at 6 again
    cyc(0, 1, OpRun, 0);
    idle(20);
    // RESET_CPU while running
    cyc(0, 1, OpRun, 0);
    idle(3);
    cyc(0, 1, OpResetCpu, 0);
    cyc(0, 1, OpRun, 0);  // dropped: CRST does not accept
    idle(3);
    // HALT coincident with the breakpoint match at PC 6
    cyc(0, 1, OpRun, 0);
    idle(3);
    cyc(0, 1, OpHalt, 0);
    idle(2);
    // STEP 0 behaves as STEP 1
    cyc(0, 1, OpStep, 0);
    idle(3);
    // Saturate the counter, then clear it while cpu_en is high
    cyc(0, 1, OpClrBp, 0);
    cyc(0, 1, OpRun, 0);
    idle(CntMax + 10);
    cyc(0, 1, OpClrCnt, 0);
    idle(2);
    cyc(0, 1, OpHalt, 0);
    idle(2);

    for (int i = 0; i < 4000; i++) begin
      logic [2:0] op;
      int arg;
      op  = 3'($urandom_range(0, 7));
      arg = (op == OpSetBp) ? 2 * $urandom_range(0, 7) : $urandom_range(0, 5);
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0, op, arg);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips16_run_ctrl.md
# mips16_run_ctrl

Run/halt/step sequencer for the 16-bit single-cycle MIPS core. It sits between the host command port and the core and produces the core's clock-enable (`cpu_en`, gating the PC and register-file/data-memory writes) and a synchronous core reset. It supports one PC breakpoint and a saturating executed-instruction counter for bring-up and debug.

## Interface
- `PC_W`, default 16: PC / breakpoint / step-argument width.
- `CNT_W`, default 16: executed-cycle counter width.
- `RST_CYCLES`, default 2: length of the `cpu_rst` pulse; must be ≥1.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `cmd_valid` in 1: host command valid.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready` at a rising edge.
- `cmd_op` in 3: 0 NOP, 1 RUN, 2 HALT, 3 STEP, 4 SET_BP, 5 CLR_BP, 6 RESET_CPU, 7 CLR_CNT.
- `cmd_arg` in PC_W: breakpoint address for SET_BP; step count for STEP.
- `pc` in PC_W: current core PC (combinational from core).
- `cpu_en` out 1: core advances one instruction at this edge when high.
- `cpu_rst` out 1: synchronous reset to core.
- `state` out 2: 0 HALT, 1 RUN, 2 STEP, 3 CRST.
- `bp_hit` out 1: sticky breakpoint-hit flag.
- `cycle_cnt` out CNT_W: number of cycles with `cpu_en`=1, saturating.

## Operation
- Reset values: state=HALT, `cpu_en`=0, `cpu_rst`=0, `bp_hit`=0, `bp_en`=0, `bp_addr`=0, `cycle_cnt`=0, step counter=0, resume flag=0, `cmd_ready`=1.
- `cmd_ready` = (state != CRST).
- HALT: `cpu_en`=0. RUN → RUN, set resume, clear `bp_hit`. STEP → STEP, load remaining = `cmd_arg`, where 0 is treated as 1; clear `bp_hit`.
- RUN: `cpu_en` = !(bp_en && pc==bp_addr && !resume). Resume clears after the first RUN cycle. On a breakpoint match: `cpu_en`=0 in that cycle, next state HALT, `bp_hit`←1. The instruction at `bp_addr` is not executed. HALT → HALT. RUN and STEP are ignored.
- STEP: `cpu_en`=1 every cycle. Remaining decrements per cycle. The cycle with remaining==1 is the last, and the next state is HALT. The breakpoint is ignored. HALT aborts to HALT. RUN and STEP are ignored.
- Accepted in any state except CRST:
  - SET_BP: `bp_addr`←arg, `bp_en`←1.
  - CLR_BP: `bp_en`←0, `bp_hit`←0.
  - CLR_CNT: `cycle_cnt`←0.
  - NOP: no effect.
- RESET_CPU, from HALT, RUN or STEP: enter CRST. `cpu_rst`=1 and `cpu_en`=0 for exactly RST_CYCLES cycles, then HALT. `cycle_cnt`←0, `bp_hit`←0. Breakpoint configuration is retained.
- `cycle_cnt` increments on edges where `cpu_en`=1 and saturates at all-ones.

## Timing
- Command latency: accepted at edge N, the new state is visible after N. The first `cpu_en` for RUN/STEP is in cycle N+1.
- `cpu_en` is combinational from registered state, `pc` and registered `bp_addr`/`bp_en`/resume. SET_BP at edge N compares from cycle N+1 onward.
- A HALT command in the same cycle as a breakpoint match goes to HALT with `bp_hit`=1; in that cycle `cpu_en`=0.
- CLR_CNT in a cycle with `cpu_en`=1: clear wins, `cycle_cnt`=0 after the edge.
- RUN from HALT with `pc`==`bp_addr`: one instruction executes (resume). Halt occurs at the next match only.
- STEP with arg=N yields exactly N `cpu_en` cycles.
- `rst` at any time overrides everything, including mid-CRST and mid-STEP, and returns to reset values at the next edge.

## Structure
- Package `mips16_dbg_pkg`:
  - `cmd_op` encodings as localparams.
  - state encoding.
  - `CPU_RST_CYCLES` default.
- Sub-module `sat_counter`, used for `cycle_cnt`. Ports: enable, clear (priority), width parameter.
- Step and CRST down-counters stay inline.

## Test plan
- Reset, then STEP arg=3 → `cpu_en` high exactly 3 cycles starting the cycle after accept; state returns to HALT; `cycle_cnt`=3.
- SET_BP 0x0006, RUN with core from PC 0 → `cpu_en` for PC 0,2,4; `cpu_en`=0 at PC 6; HALT; `bp_hit`=1; `cycle_cnt`=3.
- RUN again at PC 6 → instruction at 6 executes; `bp_hit` clears; run continues until the core wraps and PC 6 matches again → second halt.
- RESET_CPU during RUN → `cpu_rst` high 2 cycles; `cmd_ready`=0 during CRST; then HALT; `cycle_cnt`=0; `bp_addr` still 0x0006.
- Preload `cycle_cnt` near 0xFFFF via long RUN with no breakpoint → holds 0xFFFF. CLR_CNT while `cpu_en`=1 → 0.
- HALT command coincident with breakpoint match → HALT, `bp_hit`=1, no `cpu_en` that cycle. STEP arg=0 → exactly 1 `cpu_en` cycle.
